// File: rtl/soc_rom_arbiter_pkg.sv
// Shared definitions for the boot-ROM arbiter: FSM states and the boot window
// constants, also used by the bus decoder.
package soc_rom_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam int unsigned ROM_ADDR_W = 24;
  localparam logic [23:0] ROM_BASE   = 24'hffe000;
  localparam int unsigned ROM_WIN_W  = 12;

endpackage

// File: rtl/soc_rom_arbiter_rr_arb2.sv
// Two-way round-robin grant; rr_last remembers the winner of the last tie so
// the other port wins the next one.
module soc_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt
);

  logic rr_last;

  always_comb begin
    gnt = req[1];
    if (req == 2'b11) gnt = ~rr_last;
  end

  // Only a tie moves the pointer; a lone requester does not disturb it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (take && req == 2'b11) begin
      rr_last <= gnt;
    end
  end

endmodule

// File: rtl/soc_rom_arbiter.sv
// Boot-ROM port shared by instruction fetch (port 0) and data bus (port 1):
// arbitration, window decode, programmable wait states, ack/err responses.
module soc_rom_arbiter
  import soc_rom_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_W      = ROM_ADDR_W,
  parameter int unsigned       DW          = 16,
  parameter logic [ADDR_W-1:0] BASE        = ADDR_W'(ROM_BASE),
  parameter int unsigned       WIN_W       = ROM_WIN_W,
  parameter int unsigned       WAIT_STATES = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DW-1:0]     m0_dat,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DW-1:0]     m1_dat,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DW-1:0]     rom_data,
  output logic              o_busy
);

  arb_state_e        state, state_nxt;
  logic [1:0]        req;
  logic              gnt;
  logic              gnt_q;
  logic              err_q;
  logic [3:0]        cnt_q;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_adr;
  logic [ADDR_W-1:0] win_off;
  logic              hit;
  logic              bad;
  logic              gnt_cyc;

  assign req = {m1_cyc & m1_stb, m0_cyc & m0_stb};

  soc_rr_arb2 u_arb (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .req   (req),
    .take  (state == ST_IDLE),
    .gnt   (gnt)
  );

  assign sel_we  = gnt ? m1_we  : m0_we;
  assign sel_adr = gnt ? m1_adr : m0_adr;
  // Modular offset so addresses below BASE wrap high and miss the window.
  assign win_off = sel_adr - BASE;
  assign hit     = (win_off >> WIN_W) == '0;
  assign bad     = sel_we | ~hit;
  assign gnt_cyc = gnt_q ? m1_cyc : m0_cyc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    o_busy    = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (|req) state_nxt = bad ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!gnt_cyc)            state_nxt = ST_IDLE;
        else if (cnt_q == '0)    state_nxt = ST_RESP;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
        m0_ack    = ~gnt_q & ~err_q;
        m0_err    = ~gnt_q &  err_q;
        m1_ack    =  gnt_q & ~err_q;
        m1_err    =  gnt_q &  err_q;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      gnt_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      rom_addr <= '0;
      m0_dat   <= '0;
      m1_dat   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt_q <= gnt;
            err_q <= bad;
            if (bad) begin
              if (gnt) m1_dat <= '0;
              else     m0_dat <= '0;
            end else begin
              rom_addr <= sel_adr;
              cnt_q    <= 4'(WAIT_STATES);
            end
          end
        end
        ST_ACCESS: begin
          if (gnt_cyc) begin
            if (cnt_q != '0) cnt_q <= cnt_q - 4'd1;
            else if (gnt_q)  m1_dat <= rom_data;
            else             m0_dat <= rom_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_rom_arbiter.sv
// Randomized bench for soc_rom_arbiter: two instances (0 and 3 wait states)
// checked cycle by cycle against a transaction-timing reference model.
module tb_soc_rom_arbiter;

  localparam logic [23:0] BASE   = 24'hffe000;
  localparam int          WIN    = 4096;
  localparam int          M_FREE = 0;
  localparam int          M_ACC  = 1;
  localparam int          M_RESP = 2;

  logic        clk;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [23:0] m0_adr, m1_adr;

  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_busy;
  logic [15:0] a_m0_dat, a_m1_dat, a_rom_data;
  logic [23:0] a_rom_addr;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_busy;
  logic [15:0] b_m0_dat, b_m1_dat, b_rom_data;
  logic [23:0] b_rom_addr;

  function automatic logic [15:0] rom_fn(input logic [23:0] a);
    return a[15:0] ^ 16'hf234;
  endfunction

  assign a_rom_data = rom_fn(a_rom_addr);
  assign b_rom_data = rom_fn(b_rom_addr);

  soc_rom_arbiter #(.WAIT_STATES(0)) dut_ws0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_ack(a_m0_ack), .m0_err(a_m0_err), .m0_dat(a_m0_dat),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_ack(a_m1_ack), .m1_err(a_m1_err), .m1_dat(a_m1_dat),
    .rom_addr(a_rom_addr), .rom_data(a_rom_data), .o_busy(a_busy)
  );

  soc_rom_arbiter #(.WAIT_STATES(3)) dut_ws3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_ack(b_m0_ack), .m0_err(b_m0_err), .m0_dat(b_m0_dat),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_ack(b_m1_ack), .m1_err(b_m1_err), .m1_dat(b_m1_dat),
    .rom_addr(b_rom_addr), .rom_data(b_rom_data), .o_busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which port owns the ROM, and at which edge its response lands.
  bit          sel;
  int          ws;
  int          md;
  int          own;
  bit          m_err;
  int          rr_last;
  int          ecount;
  int          resp_edge;
  logic [23:0] g_adr;
  logic [23:0] m_rom;
  logic [15:0] m_dat [2];
  bit          exp_ack [2];
  bit          exp_err [2];

  bit          req_on  [2];
  logic [23:0] req_adr [2];
  bit          req_we  [2];

  function automatic bit in_window(input logic [23:0] a);
    int ai;
    ai = int'(a);
    return (ai >= int'(BASE)) && (ai < int'(BASE) + WIN);
  endfunction

  task automatic model_reset();
    md       = M_FREE;
    own      = 0;
    m_err    = 0;
    rr_last  = 1;
    ecount   = 0;
    m_rom    = '0;
    m_dat[0] = '0;
    m_dat[1] = '0;
  endtask

  task automatic model_edge();
    bit r0, r1, own_cyc;
    int g;
    ecount++;
    r0 = m0_cyc & m0_stb;
    r1 = m1_cyc & m1_stb;
    own_cyc = (own == 1) ? m1_cyc : m0_cyc;
    if (md == M_RESP) begin
      md = M_FREE;
    end else if (md == M_ACC) begin
      if (!own_cyc) begin
        md = M_FREE;
      end else if (ecount == resp_edge) begin
        md = M_RESP;
        m_dat[own] = rom_fn(g_adr);
      end
    end else if (r0 || r1) begin
      if (r0 && r1) begin
        g = 1 - rr_last;
        rr_last = g;
      end else begin
        g = r1 ? 1 : 0;
      end
      own   = g;
      g_adr = (g == 1) ? m1_adr : m0_adr;
      m_err = ((g == 1) ? m1_we : m0_we) || !in_window(g_adr);
      if (m_err) begin
        md = M_RESP;
        m_dat[g] = '0;
      end else begin
        md        = M_ACC;
        m_rom     = g_adr;
        resp_edge = ecount + ws + 1;
      end
    end
  endtask

  task automatic update_exp();
    for (int p = 0; p < 2; p++) begin
      exp_ack[p] = (md == M_RESP) && (own == p) && !m_err;
      exp_err[p] = (md == M_RESP) && (own == p) &&  m_err;
    end
  endtask

  function automatic logic [23:0] pick_adr();
    case ($urandom_range(0, 7))
      0:       return 24'hffe000;
      1:       return 24'hffdfff;
      2:       return 24'hfff000;
      3:       return 24'hffefff;
      4:       return 24'($urandom);
      default: return BASE + 24'($urandom_range(0, WIN - 1));
    endcase
  endfunction

  task automatic drive_masters();
    for (int p = 0; p < 2; p++) begin
      if (exp_ack[p] || exp_err[p]) req_on[p] = 0;
      if (req_on[p] && $urandom_range(0, 39) == 0) begin
        req_on[p] = 0;
      end else if (!req_on[p] && $urandom_range(0, 2) == 0) begin
        req_on[p]  = 1;
        req_adr[p] = pick_adr();
        req_we[p]  = ($urandom_range(0, 7) == 0);
      end else if (req_on[p] && !(md != M_FREE && own == p) && $urandom_range(0, 9) == 0) begin
        req_adr[p] = pick_adr();
      end
    end
    m0_cyc = req_on[0]; m0_stb = req_on[0]; m0_adr = req_adr[0]; m0_we = req_we[0];
    m1_cyc = req_on[1]; m1_stb = req_on[1]; m1_adr = req_adr[1]; m1_we = req_we[1];
  endtask

  task automatic compare();
    if (sel) begin
      check("m0_ack",   32'(b_m0_ack),   32'(exp_ack[0]));
      check("m0_err",   32'(b_m0_err),   32'(exp_err[0]));
      check("m1_ack",   32'(b_m1_ack),   32'(exp_ack[1]));
      check("m1_err",   32'(b_m1_err),   32'(exp_err[1]));
      check("m0_dat",   32'(b_m0_dat),   32'(m_dat[0]));
      check("m1_dat",   32'(b_m1_dat),   32'(m_dat[1]));
      check("rom_addr", 32'(b_rom_addr), 32'(m_rom));
      check("o_busy",   32'(b_busy),     32'(md != M_FREE));
    end else begin
      check("m0_ack",   32'(a_m0_ack),   32'(exp_ack[0]));
      check("m0_err",   32'(a_m0_err),   32'(exp_err[0]));
      check("m1_ack",   32'(a_m1_ack),   32'(exp_ack[1]));
      check("m1_err",   32'(a_m1_err),   32'(exp_err[1]));
      check("m0_dat",   32'(a_m0_dat),   32'(m_dat[0]));
      check("m1_dat",   32'(a_m1_dat),   32'(m_dat[1]));
      check("rom_addr", 32'(a_rom_addr), 32'(m_rom));
      check("o_busy",   32'(a_busy),     32'(md != M_FREE));
    end
  endtask

  // One clock: drive at the falling edge, step the model, sample 1 ns after the rising edge.
  task automatic cycle(input bit do_rst);
    if (do_rst) begin
      req_on[0] = 0;
      req_on[1] = 0;
    end
    drive_masters();
    if (do_rst) begin
      req_on[0] = 0;
      req_on[1] = 0;
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      rst_n = 1'b0;
      model_reset();
    end else begin
      rst_n = 1'b1;
      model_edge();
    end
    update_exp();
    @(posedge clk);
    #1;
    compare();
    @(negedge clk);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    m0_cyc  = 0; m0_stb = 0; m0_we = 0; m0_adr = '0;
    m1_cyc  = 0; m1_stb = 0; m1_we = 0; m1_adr = '0;
    for (int p = 0; p < 2; p++) begin
      req_on[p]  = 0;
      req_adr[p] = '0;
      req_we[p]  = 0;
      exp_ack[p] = 0;
      exp_err[p] = 0;
    end
    model_reset();
    @(negedge clk);
    for (int ph = 0; ph < 2; ph++) begin
      sel = (ph == 1);
      ws  = (ph == 1) ? 3 : 0;
      cycle(1'b1);
      cycle(1'b1);
      req_on[0]  = 1;
      req_we[0]  = 0;
      req_adr[0] = (ph == 1) ? 24'hffe010 : 24'hffe000;
      for (int i = 0; i < 3000; i++) begin
        cycle($urandom_range(0, 149) == 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
